// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit 8:1 mux channel among eight requesters.
// Owns the mux select and returns the granted requester's data bit as a registered output.
module mux8_rr_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy,
   output logic       valid,
   output logic       dout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] BURST = 4'(MAX_BURST);

   state_t     state;
   logic [2:0] ptr;
   logic [3:0] cnt;

   logic [7:0] others;
   logic [7:0] cand;
   logic [2:0] idx;
   logic [2:0] pick;
   logic       pick_ok;
   logic       do_grant;
   logic       hit;

   // In GRANT the search excludes the current holder; ptr already sits at holder+1.
   always_comb begin
      others  = req & ~gnt;
      cand    = (state == IDLE) ? req : others;
      idx     = ptr;
      pick    = ptr;
      pick_ok = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!pick_ok && cand[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
      if (state == IDLE)
         do_grant = pick_ok;
      else
         do_grant = pick_ok && (!req[sel] || cnt == BURST);
   end

   assign hit  = (state == GRANT) && req[sel];
   assign busy = (state == GRANT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
         valid <= 1'b0;
         dout  <= 1'b0;
      end else begin
         valid <= hit;
         dout  <= hit && din[sel];
         if (do_grant) begin
            state <= GRANT;
            gnt   <= 8'd1 << pick;
            sel   <= pick;
            ptr   <= pick + 3'd1;
            cnt   <= 4'd1;
         end else if (state == GRANT && !req[sel]) begin
            state <= IDLE;
            gnt   <= '0;
         end else if (state == GRANT && cnt != BURST) begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized scoreboard bench for mux8_rr_arbiter against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       valid;
   logic       dout;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din),
      .gnt(gnt), .sel(sel), .busy(busy), .valid(valid), .dout(dout)
   );

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic       valid;
      logic       dout;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Model: owner is the granted requester index, or -1 when idle.
   int m_owner = -1;
   int m_sel   = 0;
   int m_ptr   = 0;
   int m_cnt   = 0;

   function automatic int rr_first(input logic [7:0] v, input int start);
      for (int k = 0; k < 8; k++)
         if (v[(start + k) % 8]) return (start + k) % 8;
      return -1;
   endfunction

   function void take(input int p);
      m_owner = p;
      m_sel   = p;
      m_cnt   = 1;
      m_ptr   = (p + 1) % 8;
   endfunction

   always @(posedge clk) begin : model
      exp_t       e;
      logic [7:0] oth;
      int         p;
      if (rst) begin
         m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
         e.valid = 1'b0;
         e.dout  = 1'b0;
      end else begin
         e.valid = (m_owner >= 0) && req[m_sel];
         e.dout  = e.valid && din[m_sel];
         if (m_owner < 0) begin
            p = rr_first(req, m_ptr);
            if (p >= 0) take(p);
         end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            p = rr_first(oth, m_ptr);
            if (!req[m_owner]) begin
               if (p >= 0) take(p);
               else m_owner = -1;
            end else if (m_cnt == MB) begin
               if (p >= 0) take(p);
            end else begin
               m_cnt++;
            end
         end
      end
      e.gnt  = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      e.sel  = 3'(m_sel);
      e.busy = (m_owner >= 0);
      sbq.push_back(e);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("gnt",   gnt,   e.gnt);
         chk("sel",   sel,   e.sel);
         chk("busy",  busy,  e.busy);
         chk("valid", valid, e.valid);
         chk("dout",  dout,  e.dout);
         chk("gnt_onehot_sel",
             int'($onehot0(gnt) && (gnt == 8'h00 || gnt == (8'h01 << sel))), 1);
      end
   end

   task automatic drive(input logic r, input logic [7:0] rq, input int n,
                        input logic [7:0] d, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         rst = r;
         req = rq;
         din = rnd ? 8'($urandom) : d;
      end
   endtask

   initial begin : stim
      logic [7:0] rr;
      rst = 1'b1;
      req = '0;
      din = '0;
      drive(1, 8'h00, 2, 8'h00, 1);
      drive(0, 8'h08, 10, 8'h00, 1);
      drive(0, 8'hFF, 40, 8'h00, 1);
      drive(1, 8'h00, 1, 8'h00, 1);
      drive(0, 8'h05, 3, 8'h00, 1);
      drive(0, 8'h04, 4, 8'h00, 1);
      drive(0, 8'h00, 2, 8'h00, 1);
      drive(0, 8'h40, 3, 8'h00, 1);
      drive(0, 8'h00, 2, 8'h00, 1);
      drive(0, 8'h41, 3, 8'h00, 1);
      drive(0, 8'h10, 3, 8'h00, 1);
      drive(1, 8'h10, 1, 8'h00, 1);
      drive(0, 8'h10, 3, 8'h00, 1);
      for (int i = 0; i < 8; i++)
         drive(0, 8'h80, 1, (i % 2 == 1) ? 8'h2A : 8'hAA, 0);
      rr = '0;
      for (int i = 0; i < 300; i++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
         drive(($urandom_range(0, 63) == 0), rr, 1, 8'h00, 1);
      end
      drive(0, 8'h00, 3, 8'h00, 1);
      @(negedge clk);
      #1;
      chk("sb_drain", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares a single 1-bit 8:1 mux channel among eight requesters. It grants one requester at a time, drives the 3-bit mux select, and returns the selected requester's data as a registered output with a valid flag. A burst limit forces rotation so that no requester can starve the others. It sits in front of the 8:1 mux datapath and owns its select lines.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive grant cycles per requester while others wait. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; req[n] is held high by requester n for as long as it wants the channel
- din  input  8  data inputs; din[n] is requester n's data bit (mux inputs i0..i7)
- gnt  output  8  one-hot grant, registered; all zeros when idle
- sel  output  3  mux select {s2,s1,s0}, registered; index of the current or last grantee
- busy  output  1  high while the FSM is in GRANT
- valid  output  1  registered; dout carries a granted sample
- dout  output  1  registered selected data; 0 when valid=0

## Operation
- State: FSM {IDLE, GRANT}; ptr[2:0] round-robin start index; cnt[3:0] burst counter.
- RR pick: the first n with req[n]=1, searching ptr, ptr+1, …, ptr+7 (mod 8). The pick is n; on a grant, ptr <= n+1 mod 8.
- IDLE: if req != 0, then gnt <= onehot(pick), sel <= pick, cnt <= 1, go to GRANT. Otherwise stay, with gnt=0 and sel held.
- GRANT, with g = sel and others = req & ~gnt. Evaluated in this priority order:
  - Release (req[g]=0): if others != 0, grant RR pick of others, cnt <= 1, stay in GRANT. Otherwise gnt <= 0 and go to IDLE.
  - Forced rotation (cnt == MAX_BURST and others != 0): grant RR pick of others, cnt <= 1. The search starts at g+1, so g is never re-picked.
  - Burst limit with no other requester (cnt == MAX_BURST and others == 0): keep the grant; cnt saturates at MAX_BURST.
  - Otherwise: keep the grant, cnt <= cnt+1.
- Grant-to-grant handoff takes no idle cycle. gnt is always one-hot or zero, and sel == index(gnt) whenever gnt != 0.
- Data path, every edge:
  - valid <= (state==GRANT && req[sel]).
  - dout <= valid_next ? din[sel] : 0.
  - Both use the pre-edge sel and state.
- busy = (state == GRANT).
- Reset, whether at power-up or mid-operation:
  - State: IDLE, gnt=0, sel=0, ptr=0, cnt=0.
  - Outputs: valid=0, dout=0, busy=0.
  - Reset overrides every other condition on the same edge.

## Timing
- Request to grant latency: req high before edge k produces gnt/sel visible after edge k (1 cycle).
- Grant to data latency: valid/dout reflect din[sel] sampled at edge k+1, visible after edge k+1.
- Release: req[g] dropped before edge m clears or moves gnt after edge m. valid falls after edge m, because req[sel] was already low at edge m.
- Maximum hold under contention: exactly MAX_BURST consecutive cycles of gnt for one requester.
- Worst-case wait for a continuously asserted request: 7*MAX_BURST cycles plus 1.
- Simultaneous release and new request on the same edge: the new requester is granted that edge with no bubble.
- ptr wraps from 7 to 0. A pick of 7 sets ptr to 0.

## Test plan
- Single request, MAX_BURST=4:
  - Stimulus: req=8'h08 held from cycle 2.
  - Response: gnt=8'h08 and sel=3 after the cycle-2 edge. busy=1. valid=1 one cycle later with dout tracking din[3]. gnt holds indefinitely with cnt saturated.
- Full contention from reset:
  - Stimulus: req=8'hFF.
  - Response: gnt sequence 01,02,04,…,80,01, each held exactly 4 cycles. sel=0..7 wraps to 0 with no idle cycle.
- Early release:
  - Stimulus: req=8'h05. Requester 0 is granted first and drops req after 2 cycles.
  - Response: gnt switches to 8'h04 on the next edge. valid stays 0 for the edge where req[0] was low.
- Idle return:
  - Stimulus: sole requester 6 drops req.
  - Response: gnt=0, busy=0, valid=0 one edge later, sel stays 6. Next req=8'h41 grants 6 before 0? No: ptr=7, so requester 0 is granted.
- Reset mid-grant:
  - Stimulus: rst=1 for one cycle while gnt=8'h10 and valid=1.
  - Response: gnt=0, sel=0, valid=0, dout=0, busy=0 after that edge. With req still 8'h10, regrant occurs one edge after rst falls.
- Data mux check:
  - Stimulus: req=8'h80 and din toggled 8'hAA/8'h2A each cycle.
  - Response: dout follows bit 7 (1,0,…) with 1-cycle lag after the grant. din changes on other bits never affect dout.
